// File: rtl/capi_command_arbiter_pkg.sv
// CAPI PSL command/response bus types, command codes, and the arbiter's
// state enum plus tag compose/decompose helpers.
package capi_command_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic        command_parity;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [7:0] response;
  } ResponseInterface;

  localparam logic [12:0] CMD_READ_CL_NA = 13'h0A00;
  localparam logic [12:0] CMD_WRITE_NA   = 13'h0D00;
  localparam logic [12:0] CMD_RESTART    = 13'h0001;
  localparam logic [7:0]  RSP_DONE       = 8'h00;
  localparam logic [7:0]  RSP_AERROR     = 8'h01;

  typedef enum logic [1:0] {ARB_INIT, ARB_RUN, ARB_DRAIN} arb_state_t;

  // PSL tag = {requester index, local tag}; index occupies the top idx_w bits
  function automatic logic [7:0] tag_compose(input int idx_w, input logic [7:0] idx,
                                             input logic [7:0] local_tag);
    return (idx << (8 - idx_w)) | local_tag;
  endfunction

  function automatic logic [7:0] tag_index(input int idx_w, input logic [7:0] tag);
    return tag >> (8 - idx_w);
  endfunction

  function automatic logic [7:0] tag_local(input int idx_w, input logic [7:0] tag);
    return tag & (8'hFF >> idx_w);
  endfunction

endpackage

// File: rtl/capi_command_arbiter_round_robin_picker.sv
// Combinational round-robin pick: first eligible index at or after ptr.
module round_robin_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && eligible[(int'(ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/capi_command_arbiter.sv
// Credit-based round-robin arbiter of requester commands onto the PSL command
// bus, with response routing back by tag. CMD_ARB_PERF_EN adds perf counters.
module capi_command_arbiter
  import capi_command_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_CREDITS     = 64,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int LOC_W = 8 - IDX_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][12:0]          req_command,
  input  logic [NUM_REQ-1:0][63:0]          req_address,
  input  logic [NUM_REQ-1:0][11:0]          req_size,
  input  logic [NUM_REQ-1:0][LOC_W-1:0]     req_tag,
  output logic [NUM_REQ-1:0]                req_ready,
  output CommandInterfaceOutput             command_out,
  input  ResponseInterface                  response,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [LOC_W-1:0]                  rsp_tag,
  output logic [7:0]                        rsp_code,
  output logic [6:0]                        credits,
  output logic                              tag_error
`ifdef CMD_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]          issued_count,
  output logic [31:0]                       stall_count
`endif
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [6:0]       CRED_MAX = 7'(MAX_CREDITS);

  arb_state_t                      state;
  logic [NUM_REQ-1:0][OUT_W-1:0]   outstanding;
  logic [IDX_W-1:0]                ptr;
  logic [NUM_REQ-1:0]              eligible, grant;
  logic [IDX_W-1:0]                grant_idx;
  logic                            grant_any;
  logic                            cmd_valid;
  logic [12:0]                     cmd_command;
  logic [63:0]                     cmd_address;
  logic [11:0]                     cmd_size;
  logic [7:0]                      cmd_tag;
  logic [7:0]                      rsp_idx_w;
  logic [IDX_W-1:0]                rsp_idx;
  logic                            rsp_in_range, rsp_underflow;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
    assign eligible[i] = req_valid[i] && enable && (credits != 7'd0) && (outstanding[i] < OUT_MAX);
  end

  round_robin_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready     = grant;
  assign rsp_idx_w     = tag_index(IDX_W, response.tag);
  assign rsp_idx       = rsp_idx_w[IDX_W-1:0];
  assign rsp_in_range  = rsp_idx_w < 8'(NUM_REQ);
  assign rsp_underflow = rsp_in_range && (outstanding[rsp_idx] == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ARB_INIT;
      credits <= 7'd0;
      ptr     <= '0;
    end else begin
      unique case (state)
        ARB_INIT:  state <= ARB_RUN;
        ARB_RUN:   if (!enable) state <= ARB_DRAIN;
        ARB_DRAIN: if (enable) state <= ARB_RUN;
        default:   state <= ARB_INIT;
      endcase
      if (state == ARB_INIT)
        credits <= CRED_MAX;
      else if (grant_any && !response.valid)
        credits <= credits - 7'd1;
      else if (!grant_any && response.valid && credits != CRED_MAX)
        credits <= credits + 7'd1;
      if (grant_any)
        ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // A response for an idle requester never decrements, so the counter cannot wrap
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_out
    logic dec;
    assign dec = response.valid && rsp_in_range && (int'(rsp_idx) == i) && (outstanding[i] != '0);
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                outstanding[i] <= '0;
      else if (grant[i] && !dec) outstanding[i] <= outstanding[i] + OUT_W'(1);
      else if (dec && !grant[i]) outstanding[i] <= outstanding[i] - OUT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_error <= 1'b0;
    end else if (response.valid && (!rsp_in_range || rsp_underflow ||
               (state != ARB_INIT && !grant_any && credits == CRED_MAX))) begin
      tag_error <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd_command <= '0;
      cmd_address <= '0;
      cmd_size    <= '0;
      cmd_tag     <= '0;
      rsp_valid   <= '0;
      rsp_tag     <= '0;
      rsp_code    <= '0;
    end else begin
      cmd_valid <= grant_any;
      if (grant_any) begin
        cmd_command <= req_command[grant_idx];
        cmd_address <= req_address[grant_idx];
        cmd_size    <= req_size[grant_idx];
        cmd_tag     <= tag_compose(IDX_W, 8'(grant_idx), 8'(req_tag[grant_idx]));
      end
      rsp_valid <= (response.valid && rsp_in_range) ? (NUM_REQ'(1) << rsp_idx) : '0;
      if (response.valid) begin
        rsp_tag  <= LOC_W'(tag_local(IDX_W, response.tag));
        rsp_code <= response.response;
      end
    end
  end

  always_comb begin
    command_out                = '0;
    command_out.valid          = cmd_valid;
    command_out.command        = cmd_command;
    command_out.command_parity = ~^cmd_command;
    command_out.tag            = cmd_tag;
    command_out.tag_parity     = ~^cmd_tag;
    command_out.address        = cmd_address;
    command_out.address_parity = ~^cmd_address;
    command_out.size           = cmd_size;
  end

`ifdef CMD_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) issued_count[i] <= issued_count[i] + 32'd1;
      if (|req_valid && !grant_any) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_capi_command_arbiter.sv
// Directed bench for capi_command_arbiter with a per-cycle reference model.
module tb_capi_command_arbiter;
  import capi_command_arbiter_pkg::*;

  localparam int NR = 4, MAXC = 64, MAXO = 16, LW = 6;

  logic clock = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0][12:0] req_command;
  logic [NR-1:0][63:0] req_address;
  logic [NR-1:0][11:0] req_size;
  logic [NR-1:0][LW-1:0] req_tag;
  logic [NR-1:0] req_ready, rsp_valid;
  CommandInterfaceOutput command_out;
  ResponseInterface response = '0;
  logic [LW-1:0] rsp_tag;
  logic [7:0] rsp_code;
  logic [6:0] credits;
  logic tag_error;

  logic [2:0] req_valid3 = '0;
  logic [2:0][12:0] req_command3 = '0;
  logic [2:0][63:0] req_address3 = '0;
  logic [2:0][11:0] req_size3 = '0;
  logic [2:0][5:0] req_tag3 = '0;
  logic [2:0] req_ready3, rsp_valid3;
  CommandInterfaceOutput command_out3;
  ResponseInterface response3 = '0;
  logic [5:0] rsp_tag3;
  logic [7:0] rsp_code3;
  logic [6:0] credits3;
  logic tag_error3;

  int checks = 0, errors = 0;

  capi_command_arbiter #(.NUM_REQ(NR)) u_dut (
    .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid),
    .req_command(req_command), .req_address(req_address), .req_size(req_size),
    .req_tag(req_tag), .req_ready(req_ready), .command_out(command_out),
    .response(response), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
    .rsp_code(rsp_code), .credits(credits), .tag_error(tag_error));

  capi_command_arbiter #(.NUM_REQ(3)) u_dut3 (
    .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid3),
    .req_command(req_command3), .req_address(req_address3), .req_size(req_size3),
    .req_tag(req_tag3), .req_ready(req_ready3), .command_out(command_out3),
    .response(response3), .rsp_valid(rsp_valid3), .rsp_tag(rsp_tag3),
    .rsp_code(rsp_code3), .credits(credits3), .tag_error(tag_error3));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_par(input logic [63:0] v, input int w);
    int n = 0;
    for (int i = 0; i < w; i++) n += int'(v[i]);
    return (n % 2) == 0;
  endfunction

  // reference model state and predicted registered outputs
  int m_cred, m_ptr, m_out[NR];
  logic m_err, m_init;
  logic e_cvalid;
  logic [12:0] e_ccmd;
  logic [63:0] e_caddr;
  logic [11:0] e_csize;
  logic [7:0] e_ctag;
  logic [NR-1:0] e_rvalid;
  int e_rtag, e_rcode;

  always @(negedge clock) begin
    int g, c, idx, loc;
    logic [NR-1:0] er;
    if (reset) begin
      m_cred = 0; m_ptr = 0; m_err = 0; m_init = 1; e_cvalid = 0;
      for (int i = 0; i < NR; i++) m_out[i] = 0;
      e_rvalid = '0; e_rtag = 0; e_rcode = 0;
      chk("rst_credits", credits, 0);
      chk("rst_cmd_valid", command_out.valid, 0);
      chk("rst_cmd_fields", {command_out.command, command_out.size, command_out.tag}, 0);
      chk("rst_cmd_addr", command_out.address, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_tag, rsp_code}, 0);
      chk("rst_tag_error", tag_error, 0);
    end else begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (g < 0 && req_valid[c] && enable && m_cred > 0 && m_out[c] < MAXO) g = c;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("credits", credits, m_cred);
      chk("tag_error", tag_error, m_err);
      chk("cmd_valid", command_out.valid, e_cvalid);
      if (e_cvalid) begin
        chk("cmd_command", command_out.command, e_ccmd);
        chk("cmd_address", command_out.address, e_caddr);
        chk("cmd_size", command_out.size, e_csize);
        chk("cmd_tag", command_out.tag, e_ctag);
        chk("cmd_zero_fields", {command_out.abt, command_out.context_handle}, 0);
        chk("cmd_parity", {command_out.command_parity, command_out.address_parity, command_out.tag_parity},
            {odd_par(64'(e_ccmd), 13), odd_par(e_caddr, 64), odd_par(64'(e_ctag), 8)});
      end
      chk("rsp_valid", rsp_valid, e_rvalid);
      if (e_rvalid != '0) chk("rsp_tag_code", {rsp_tag, rsp_code}, {6'(e_rtag), 8'(e_rcode)});
      // predict the state after the coming edge
      e_rvalid = '0;
      if (response.valid) begin
        idx = int'(response.tag) / (1 << LW);
        loc = int'(response.tag) % (1 << LW);
        e_rvalid[idx] = 1'b1; e_rtag = loc; e_rcode = int'(response.response);
        if (m_out[idx] == 0) m_err = 1; else m_out[idx]--;
      end
      e_cvalid = (g >= 0);
      if (g >= 0) begin
        e_ccmd = req_command[g]; e_caddr = req_address[g]; e_csize = req_size[g];
        e_ctag = 8'(g * (1 << LW) + int'(req_tag[g]));
        m_out[g]++;
        m_ptr = (g + 1) % NR;
      end
      if (m_init) begin
        m_cred = MAXC; m_init = 0;
      end else if (response.valid && g < 0 && m_cred == MAXC) begin
        m_err = 1;
      end else begin
        m_cred = m_cred + (response.valid ? 1 : 0) - (g >= 0 ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; repeat (3) tick();
    reset = 1'b0; tick(); tick();
  endtask

  task automatic rsp(input logic [7:0] tag, input logic [7:0] code);
    response = '{valid: 1'b1, tag: tag, response: code};
    tick();
    response = '0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      req_command[i] = CMD_READ_CL_NA + 13'(i);
      req_address[i] = 64'h1000 * 64'(i + 1) + 64'h8;
      req_size[i]    = 12'd128 + 12'(i);
      req_tag[i]     = LW'(i + 3);
    end
    do_reset();

    // single requester
    req_tag[2] = 6'd5; req_address[2] = 64'h1000; req_command[2] = CMD_WRITE_NA;
    req_valid = 4'b0100; #1;
    chk("single_ready", req_ready, 4'b0100);
    tick(); req_valid = '0;
    chk("single_valid", command_out.valid, 1);
    chk("single_tag", command_out.tag, 8'h85);
    chk("single_addr", command_out.address, 64'h1000);
    chk("single_credits", credits, 63);
    tick();

    // round-robin fairness from a fresh pointer
    do_reset();
    req_valid = 4'b1111; #1;
    chk("rr_0", req_ready, 4'b0001); tick();
    chk("rr_1", req_ready, 4'b0010); tick();
    chk("rr_2", req_ready, 4'b0100); tick();
    chk("rr_3", req_ready, 4'b1000); tick();
    chk("rr_4", req_ready, 4'b0001); tick();
    req_valid = '0; tick();

    // grant and response in the same cycle
    req_valid = 4'b1000;
    rsp(8'h41, RSP_DONE);
    req_valid = '0;
    chk("sim_credits", credits, 59);
    chk("sim_rsp_valid", rsp_valid, 4'b0010);
    chk("sim_rsp_tag", rsp_tag, 1);
    rsp(8'h00, RSP_DONE); rsp(8'h03, RSP_AERROR); rsp(8'h85, RSP_DONE);
    rsp(8'hC6, RSP_DONE); rsp(8'hC6, RSP_DONE);
    tick();

    // enable low blocks grants but responses still route
    enable = 1'b0; req_valid = 4'b1111; tick();
    chk("dis_ready", req_ready, 0);
    tick();
    enable = 1'b1; req_valid = '0; tick();

    // bad tags
    do_reset();
    req_valid = 4'b0010; req_valid3 = 3'b001; tick();
    req_valid = '0; req_valid3 = '0;
    response3 = '{valid: 1'b1, tag: 8'hC0, response: RSP_DONE};
    rsp(8'h05, RSP_DONE);
    response3 = '0;
    chk("bad_err", tag_error, 1);
    chk("bad_credits", credits, 64);
    chk("bad3_err", tag_error3, 1);
    chk("bad3_rsp_valid", rsp_valid3, 0);
    chk("bad3_credits", credits3, 64);
    tick();

    // per-requester outstanding limit
    do_reset();
    n = 0; req_valid = 4'b0010; #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready[1]) n++;
      tick();
    end
    req_valid = '0;
    chk("limit_grants", n, 16);
    tick();

    // credit exhaustion
    do_reset();
    n = 0; req_valid = 4'b1111; #1;
    for (int i = 0; i < 70; i++) begin
      if (req_ready != 0) n++;
      tick();
    end
    chk("exh_grants", n, 64);
    chk("exh_credits", credits, 0);
    rsp(8'h00, RSP_DONE);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_ready != 0) n++;
      tick();
    end
    chk("exh_one_more", n, 1);
    req_valid = '0; tick();

    // reset mid-burst
    do_reset();
    req_valid = 4'b1111; repeat (10) tick();
    req_valid = '0; #2;
    reset = 1'b1; #1;
    chk("mid_credits", credits, 0);
    chk("mid_cmd_valid", command_out.valid, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    tick(); tick();
    reset = 1'b0; tick(); tick();
    chk("mid_reload", credits, 64);
    rsp(8'h00, RSP_DONE);
    chk("mid_late_rsp_err", tag_error, 1);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
